// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-busy freeze and interrupt entry.
// Define HAZARD_IRQ_EN to build the interrupt drain/enter sequence; otherwise irq inputs are ignored.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_ID,
  input  logic [31:0] instr_EX,
  input  logic        mem_rden_EX,
  input  logic        br_taken_EX,
  input  logic        mem_busy,
  input  logic        irq_req,
  input  logic        irq_en,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        stall_EX,
  output logic        stall_MEM,
  output logic        flush_ID,
  output logic        flush_EX,
  output logic        irq_take,
  output logic        irq_ack,
  output logic [2:0]  state_o
);

  // MEM_WAIT keeps its encoding for software visibility, but a busy memory freezes the
  // current state in place so the interrupted sequence resumes without a saved return state.
  typedef enum logic [2:0] {
    RUN       = 3'd0,
    LU_STALL  = 3'd1,
    MEM_WAIT  = 3'd2,
    IRQ_DRAIN = 3'd3,
    IRQ_ENTER = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_state_valid;
  logic        w_load_use;
  logic [4:0]  w_rd_EX;
  logic [4:0]  w_rs1_ID;
  logic [4:0]  w_rs2_ID;
  logic        w_unused;

`ifdef HAZARD_IRQ_EN
  logic [1:0]  r_drain_cnt;
  logic [1:0]  w_drain_cnt_nxt;
`endif

  assign w_rd_EX  = instr_EX[11:7];
  assign w_rs1_ID = instr_ID[19:15];
  assign w_rs2_ID = instr_ID[24:20];

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign w_load_use = mem_rden_EX && (w_rd_EX != 5'd0) &&
                      ((w_rd_EX == w_rs1_ID) || (w_rd_EX == w_rs2_ID));

`ifdef HAZARD_IRQ_EN
  assign w_unused = ^{instr_ID[31:25], instr_ID[14:0], instr_EX[31:12], instr_EX[6:0]};
`else
  assign w_unused = ^{instr_ID[31:25], instr_ID[14:0], instr_EX[31:12], instr_EX[6:0],
                      irq_req, irq_en};
`endif

  assign state_o = r_state;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
`ifdef HAZARD_IRQ_EN
      r_drain_cnt <= 2'd0;
`endif
    end else begin
      r_state     <= w_state_nxt;
`ifdef HAZARD_IRQ_EN
      r_drain_cnt <= w_drain_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_valid = 1'b0;
    case (r_state)
      RUN, LU_STALL:        w_state_valid = 1'b1;
`ifdef HAZARD_IRQ_EN
      IRQ_DRAIN, IRQ_ENTER: w_state_valid = 1'b1;
`endif
      default:              w_state_valid = 1'b0;
    endcase
  end

  // Priority: reset, illegal state, mem_busy, branch, load-use, interrupt.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_state_nxt     = r_state;
`ifdef HAZARD_IRQ_EN
    w_drain_cnt_nxt = r_drain_cnt;
`endif
    stall_IF        = 1'b0;
    stall_ID        = 1'b0;
    stall_EX        = 1'b0;
    stall_MEM       = 1'b0;
    flush_ID        = 1'b0;
    flush_EX        = 1'b0;
    irq_take        = 1'b0;
    irq_ack         = 1'b0;

    if (rst) begin
      w_state_nxt = RUN;
    end else if (!w_state_valid) begin
      w_state_nxt = RUN;
    end else if (mem_busy) begin
      stall_IF  = 1'b1;
      stall_ID  = 1'b1;
      stall_EX  = 1'b1;
      stall_MEM = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (br_taken_EX) begin
            flush_ID = 1'b1;
            flush_EX = 1'b1;
          end else if (w_load_use) begin
            stall_IF    = 1'b1;
            stall_ID    = 1'b1;
            flush_EX    = 1'b1;
            w_state_nxt = LU_STALL;
          end
`ifdef HAZARD_IRQ_EN
          else if (irq_req && irq_en) begin
            w_state_nxt     = IRQ_DRAIN;
            w_drain_cnt_nxt = 2'd2;
          end
`endif
        end

        LU_STALL: begin
          if (br_taken_EX) begin
            flush_ID = 1'b1;
            flush_EX = 1'b1;
          end
          w_state_nxt = RUN;
        end

`ifdef HAZARD_IRQ_EN
        IRQ_DRAIN: begin
          stall_IF = 1'b1;
          flush_ID = 1'b1;
          // A redirect lands new work in the pipe, so the drain restarts from full length.
          if (br_taken_EX) begin
            flush_EX        = 1'b1;
            w_drain_cnt_nxt = 2'd2;
          end else if (r_drain_cnt <= 2'd1) begin
            w_drain_cnt_nxt = 2'd0;
            w_state_nxt     = IRQ_ENTER;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt - 2'd1;
          end
        end

        IRQ_ENTER: begin
          irq_take    = 1'b1;
          irq_ack     = 1'b1;
          flush_ID    = 1'b1;
          flush_EX    = 1'b1;
          w_state_nxt = RUN;
        end
`endif

        default: w_state_nxt = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pinned sequences followed by randomized traffic,
// all compared every cycle against a rule-level reference model.
module tb_hazard_ctrl;

`ifdef HAZARD_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  // Output vector order: stall_IF stall_ID stall_EX stall_MEM flush_ID flush_EX irq_take irq_ack
  localparam logic [7:0] O_NONE     = 8'h00;
  localparam logic [7:0] O_LU       = 8'hC4;
  localparam logic [7:0] O_BR       = 8'h0C;
  localparam logic [7:0] O_BUSY     = 8'hF0;
  localparam logic [7:0] O_DRAIN    = IRQ_BUILD ? 8'h88 : 8'h00;
  localparam logic [7:0] O_DRAIN_BR = IRQ_BUILD ? 8'h8C : 8'h0C;
  localparam logic [7:0] O_ENTER    = IRQ_BUILD ? 8'h0F : 8'h00;
  localparam int         S_DRAIN    = IRQ_BUILD ? 3 : 0;
  localparam int         S_ENTER    = IRQ_BUILD ? 4 : 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_ID, instr_EX;
  logic        mem_rden_EX, br_taken_EX, mem_busy, irq_req, irq_en;
  logic        stall_IF, stall_ID, stall_EX, stall_MEM;
  logic        flush_ID, flush_EX, irq_take, irq_ack;
  logic [2:0]  state_o;
  logic [7:0]  w_outs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: phase number as published on state_o, and drain cycles left.
  int   m_state  = 0;
  int   m_cnt    = 0;
  int   m_nstate = 0;
  int   m_ncnt   = 0;
  logic [7:0] m_exp;

  hazard_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .instr_ID   (instr_ID),
    .instr_EX   (instr_EX),
    .mem_rden_EX(mem_rden_EX),
    .br_taken_EX(br_taken_EX),
    .mem_busy   (mem_busy),
    .irq_req    (irq_req),
    .irq_en     (irq_en),
    .stall_IF   (stall_IF),
    .stall_ID   (stall_ID),
    .stall_EX   (stall_EX),
    .stall_MEM  (stall_MEM),
    .flush_ID   (flush_ID),
    .flush_EX   (flush_EX),
    .irq_take   (irq_take),
    .irq_ack    (irq_ack),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  assign w_outs = {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, irq_take, irq_ack};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input int rd, input int rs1, input int rs2);
    logic [31:0] r;
    r        = $urandom;
    r[11:7]  = rd[4:0];
    r[19:15] = rs1[4:0];
    r[24:20] = rs2[4:0];
    return r;
  endfunction

  // Rule-level model: what the pipeline must see this cycle, and which phase follows.
  function automatic void model(input int st, input int cnt,
                                output logic [7:0] o, output int nst, output int ncnt);
    int  rd;
    bit  lu;
    bit  legal;
    rd    = int'(instr_EX[11:7]);
    lu    = mem_rden_EX && (rd != 0) &&
            (rd == int'(instr_ID[19:15]) || rd == int'(instr_ID[24:20]));
    legal = (st == 0) || (st == 1) || (IRQ_BUILD && (st == 3 || st == 4));
    o     = O_NONE;
    nst   = st;
    ncnt  = cnt;
    if (rst) begin
      nst  = 0;
      ncnt = 0;
    end else if (!legal) begin
      nst = 0;
    end else if (mem_busy) begin
      o = O_BUSY;
    end else if (st == 0) begin
      if (br_taken_EX)                      o = O_BR;
      else if (lu)                          begin o = O_LU; nst = 1; end
      else if (IRQ_BUILD && irq_req && irq_en) begin nst = 3; ncnt = 2; end
    end else if (st == 1) begin
      o   = br_taken_EX ? O_BR : O_NONE;
      nst = 0;
    end else if (st == 3) begin
      if (br_taken_EX) begin
        o    = 8'h8C;
        ncnt = 2;
      end else begin
        o    = 8'h88;
        ncnt = cnt - 1;
        if (ncnt == 0) nst = 4;
      end
    end else begin
      o   = 8'h0F;
      nst = 0;
    end
  endfunction

  always @(negedge clk) begin
    model(m_state, m_cnt, m_exp, m_nstate, m_ncnt);
    check("model_outputs", {24'd0, w_outs}, {24'd0, m_exp});
    check("model_state", {29'd0, state_o}, m_state);
  end

  always @(posedge clk) begin
    m_state = m_nstate;
    m_cnt   = m_ncnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst         = 1'b0;
    instr_ID    = 32'h0000_0013;
    instr_EX    = 32'h0000_0013;
    mem_rden_EX = 1'b0;
    br_taken_EX = 1'b0;
    mem_busy    = 1'b0;
    irq_req     = 1'b0;
    irq_en      = 1'b0;
  endtask

  task automatic pin(input string name, input logic [7:0] exp_o, input int exp_s);
    @(negedge clk);
    check({name, "_outs"}, {24'd0, w_outs}, {24'd0, exp_o});
    check({name, "_state"}, {29'd0, state_o}, exp_s);
  endtask

  task automatic set_load_use();
    instr_EX    = {12'h004, 5'd2, 3'b010, 5'd5, 7'b0000011};   // lw x5, 4(x2)
    instr_ID    = {7'd0, 5'd7, 5'd5, 3'b000, 5'd6, 7'b0110011}; // add x6, x5, x7
    mem_rden_EX = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    pin("reset", O_NONE, 0);
    tick();

    // lw x5 followed by a dependent add: one stall cycle, one bubble cycle, back to run.
    idle();
    set_load_use();
    pin("lu_c0", O_LU, 0);
    tick();
    pin("lu_c1", O_NONE, 1);
    tick();
    idle();
    pin("lu_c2", O_NONE, 0);
    tick();

    // Load to x0 with a consumer of x0: no dependency.
    instr_EX    = {12'h000, 5'd1, 3'b010, 5'd0, 7'b0000011};
    instr_ID    = {7'd0, 5'd0, 5'd0, 3'b000, 5'd9, 7'b0110011};
    mem_rden_EX = 1'b1;
    pin("x0_c0", O_NONE, 0);
    tick();
    pin("x0_c1", O_NONE, 0);
    tick();

    // Branch and load-use together: branch wins, no stall.
    idle();
    set_load_use();
    br_taken_EX = 1'b1;
    pin("br_lu_c0", O_BR, 0);
    tick();
    idle();
    pin("br_lu_c1", O_NONE, 0);
    tick();

    // Memory busy on top of a load-use hazard freezes everything, hazard resolves after.
    set_load_use();
    mem_busy = 1'b1;
    pin("busy_lu_c0", O_BUSY, 0);
    tick();
    mem_busy = 1'b0;
    pin("busy_lu_c1", O_LU, 0);
    tick();
    idle();
    pin("busy_lu_c2", O_NONE, 1);
    tick();

    // Interrupt: request dropped after acceptance still completes the sequence.
    irq_req = 1'b1;
    irq_en  = 1'b1;
    pin("irq_c0", O_NONE, 0);
    tick();
    irq_req = 1'b0;
    pin("irq_c1", O_DRAIN, S_DRAIN);
    tick();
    pin("irq_c2", O_DRAIN, S_DRAIN);
    tick();
    pin("irq_c3", O_ENTER, S_ENTER);
    tick();
    pin("irq_c4", O_NONE, 0);
    tick();

    // Interrupt with memory busy for three cycles while one drain cycle remains.
    irq_req = 1'b1;
    irq_en  = 1'b1;
    pin("irqb_c0", O_NONE, 0);
    tick();
    irq_req = 1'b0;
    pin("irqb_c1", O_DRAIN, S_DRAIN);
    tick();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pin("irqb_busy", O_BUSY, S_DRAIN);
      tick();
    end
    mem_busy = 1'b0;
    pin("irqb_c5", O_DRAIN, S_DRAIN);
    tick();
    pin("irqb_c6", O_ENTER, S_ENTER);
    tick();
    pin("irqb_c7", O_NONE, 0);
    tick();

    // Branch mid-drain reloads the drain length.
    irq_req = 1'b1;
    irq_en  = 1'b1;
    pin("irqbr_c0", O_NONE, 0);
    tick();
    irq_req = 1'b0;
    pin("irqbr_c1", O_DRAIN, S_DRAIN);
    tick();
    br_taken_EX = 1'b1;
    pin("irqbr_c2", O_DRAIN_BR, S_DRAIN);
    tick();
    br_taken_EX = 1'b0;
    pin("irqbr_c3", O_DRAIN, S_DRAIN);
    tick();
    pin("irqbr_c4", O_DRAIN, S_DRAIN);
    tick();
    pin("irqbr_c5", O_ENTER, S_ENTER);
    tick();

    // Reset on the last drain cycle abandons the interrupt entry.
    irq_req = 1'b1;
    irq_en  = 1'b1;
    pin("irqrst_c0", O_NONE, 0);
    tick();
    pin("irqrst_c1", O_DRAIN, S_DRAIN);
    tick();
    irq_req = 1'b0;
    rst     = 1'b1;
    pin("irqrst_c2", O_NONE, S_DRAIN);
    tick();
    rst = 1'b0;
    pin("irqrst_c3", O_NONE, 0);
    tick();
    pin("irqrst_c4", O_NONE, 0);
    tick();

    // Randomized traffic; small register indices make hazards frequent.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 79) == 0);
      instr_EX    = mk_instr($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31));
      instr_ID    = mk_instr($urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 3));
      mem_rden_EX = ($urandom_range(0, 1) == 0);
      br_taken_EX = ($urandom_range(0, 6) == 0);
      mem_busy    = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) irq_req = ~irq_req;
      if ($urandom_range(0, 15) == 0) irq_en = ~irq_en;
      tick();
    end

    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
